// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timebase and BCD counter.
package stopwatch_pkg;

   localparam int unsigned BCD_W    = 4;
   localparam int unsigned DIGITS_W = 4 * BCD_W;

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef logic [BCD_W-1:0] bcd_t;

   localparam bcd_t SEC_TENS_MAX = 4'd5;
   localparam bcd_t BCD_MAX      = 4'd9;

   typedef struct packed {
      bcd_t sec_tens;
      bcd_t sec_ones;
      bcd_t hund_tens;
      bcd_t hund_ones;
   } time_t;

   // True at 59.99, the last value before rollover.
   function automatic logic at_max(input time_t t);
      return (t.sec_tens == SEC_TENS_MAX) && (t.sec_ones == BCD_MAX) &&
             (t.hund_tens == BCD_MAX) && (t.hund_ones == BCD_MAX);
   endfunction

   // One hundredth-second increment with full BCD carry chain.
   function automatic time_t time_inc(input time_t t);
      time_t r;
      r = t;
      if (t.hund_ones == BCD_MAX) begin
         r.hund_ones = '0;
         if (t.hund_tens == BCD_MAX) begin
            r.hund_tens = '0;
            if (t.sec_ones == BCD_MAX) begin
               r.sec_ones = '0;
               if (t.sec_tens == SEC_TENS_MAX) r.sec_tens = '0;
               else                            r.sec_tens = t.sec_tens + 4'd1;
            end else begin
               r.sec_ones = t.sec_ones + 4'd1;
            end
         end else begin
            r.hund_tens = t.hund_tens + 4'd1;
         end
      end else begin
         r.hund_ones = t.hund_ones + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Hundredth-second prescaler: counts while enabled, holds while disabled, clr zeroes it.
module tick_gen #(
   parameter int unsigned TICK_DIV = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n)        cnt_q <= '0;
      else if (clr)      cnt_q <= '0;
      else if (en)       cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch run/stop FSM, 100 Hz timebase and SS.hh BCD counter.
// Optional lap-hold display freeze enabled by `STOPWATCH_LAP_EN.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ready,
   input  logic                start_stop,
   input  logic                clear,
   input  logic                lap,
   output logic [DIGITS_W-1:0] digits,
   output logic                running,
   output logic                wrap,
   output logic                lap_active
);

   state_e state_q, state_d;
   time_t  cnt_q, cnt_d;
   logic   running_q, wrap_q;
   logic   run_en, do_clear, tick;

   assign run_en   = (state_q == ST_RUN);
   assign do_clear = clear && (state_q == ST_STOP);

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (run_en),
      .clr   (do_clear),
      .tick  (tick)
   );

   // Next state and next count; clear beats start_stop while stopped.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_STOP: if (start_stop && ready && !clear) state_d = ST_RUN;
         ST_RUN:  if (start_stop || !ready)          state_d = ST_STOP;
         default:                                    state_d = ST_STOP;
      endcase
      if (do_clear)  cnt_d = '0;
      else if (tick) cnt_d = time_inc(cnt_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_STOP;
         cnt_q     <= '0;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         running_q <= (state_d == ST_RUN);
         wrap_q    <= tick && at_max(cnt_q);
      end
   end

   assign running = running_q;
   assign wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
   logic  lap_q, lap_d;
   time_t disp_q, disp_d;

   // Display follows the live count unless lapped; entering lap latches the current count.
   always_comb begin
      lap_d = lap_q;
      if (do_clear)                             lap_d = 1'b0;
      else if (lap && (run_en || lap_q))        lap_d = !lap_q;
      disp_d = cnt_d;
      if (lap_d) disp_d = lap_q ? disp_q : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lap_q  <= 1'b0;
         disp_q <= '0;
      end else begin
         lap_q  <= lap_d;
         disp_q <= disp_d;
      end
   end

   assign digits     = disp_q;
   assign lap_active = lap_q;
`else
   logic lap_unused;
   assign lap_unused = lap;
   assign digits     = cnt_q;
   assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core with TICK_DIV = 4.
module tb_stopwatch_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ready = 1'b0;
   logic        start_stop = 1'b0;
   logic        clear = 1'b0;
   logic        lap = 1'b0;
   logic [15:0] digits;
   logic        running, wrap, lap_active;

   int tests = 0;
   int fails = 0;

   stopwatch_core #(.TICK_DIV(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ready      (ready),
      .start_stop (start_stop),
      .clear      (clear),
      .lap        (lap),
      .digits     (digits),
      .running    (running),
      .wrap       (wrap),
      .lap_active (lap_active)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_ss;
      start_stop = 1'b1; cyc(1); start_stop = 1'b0;
   endtask

   task automatic pulse_lap;
      lap = 1'b1; cyc(1); lap = 1'b0;
   endtask

   task automatic do_reset;
      rst_n = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0; ready = 1'b1;
      cyc(3);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; ready = 1'b1; start_stop = 1'b1;
      cyc(3);
      tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL reset_digits: got %h want 0000", digits); end
      tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b want 0", running); end
      tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap: got %b want 0", wrap); end
      tests++; if (lap_active !== 1'b0) begin fails++; $display("FAIL reset_lap: got %b want 0", lap_active); end
      rst_n = 1'b1; start_stop = 1'b0;
      cyc(1);
      tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_release: running=%b want 0", running); end
   endtask

   task automatic test_start;
      do_reset();
      pulse_ss();
      tests++; if (running !== 1'b1) begin fails++; $display("FAIL start_running: got %b want 1", running); end
      cyc(3);
      tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL start_lat3: got %h want 0000", digits); end
      cyc(1);
      tests++; if (digits !== 16'h0001) begin fails++; $display("FAIL start_lat4: got %h want 0001", digits); end
      cyc(36);
      tests++; if (digits !== 16'h0010) begin fails++; $display("FAIL start_40: got %h want 0010", digits); end
      cyc(360);
      tests++; if (digits !== 16'h0100) begin fails++; $display("FAIL start_400: got %h want 0100", digits); end
   endtask

   task automatic test_ready_gate;
      do_reset();
      ready = 1'b0;
      pulse_ss();
      tests++; if (running !== 1'b0) begin fails++; $display("FAIL gate_nostart: running=%b want 0", running); end
      cyc(8);
      tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL gate_idle: got %h want 0000", digits); end
      ready = 1'b1;
      pulse_ss();
      tests++; if (running !== 1'b1) begin fails++; $display("FAIL gate_start: running=%b want 1", running); end
      cyc(12);
      tests++; if (digits !== 16'h0003) begin fails++; $display("FAIL gate_0003: got %h want 0003", digits); end
      ready = 1'b0;
      cyc(1);
      tests++; if (running !== 1'b0) begin fails++; $display("FAIL gate_drop_run: running=%b want 0", running); end
      cyc(8);
      tests++; if (digits !== 16'h0003) begin fails++; $display("FAIL gate_hold: got %h want 0003", digits); end
      // ready falls during the tick cycle: the tick still lands
      do_reset();
      pulse_ss();
      cyc(3);
      ready = 1'b0;
      cyc(1);
      tests++; if (digits !== 16'h0001) begin fails++; $display("FAIL gate_tickdrop: got %h want 0001", digits); end
      tests++; if (running !== 1'b0) begin fails++; $display("FAIL gate_tickdrop_run: running=%b want 0", running); end
      ready = 1'b1;
   endtask

   task automatic test_clear;
      do_reset();
      pulse_ss();
      cyc(20);
      tests++; if (digits !== 16'h0005) begin fails++; $display("FAIL clr_pre: got %h want 0005", digits); end
      clear = 1'b1; cyc(1); clear = 1'b0;
      tests++; if (digits !== 16'h0005 || running !== 1'b1) begin fails++; $display("FAIL clr_in_run: digits=%h running=%b want 0005 1", digits, running); end
      cyc(3);
      tests++; if (digits !== 16'h0006) begin fails++; $display("FAIL clr_phase: got %h want 0006", digits); end
      pulse_ss();
      tests++; if (running !== 1'b0) begin fails++; $display("FAIL clr_stop: running=%b want 0", running); end
      clear = 1'b1; start_stop = 1'b1;
      cyc(1);
      clear = 1'b0; start_stop = 1'b0;
      tests++; if (digits !== 16'h0000 || running !== 1'b0) begin fails++; $display("FAIL clr_both: digits=%h running=%b want 0000 0", digits, running); end
      cyc(2);
      tests++; if (running !== 1'b0) begin fails++; $display("FAIL clr_stay: running=%b want 0", running); end
      pulse_ss();
      cyc(3);
      tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL clr_presc3: got %h want 0000", digits); end
      cyc(1);
      tests++; if (digits !== 16'h0001) begin fails++; $display("FAIL clr_presc4: got %h want 0001", digits); end
   endtask

   task automatic test_stop_resume;
      do_reset();
      pulse_ss();
      cyc(2);
      pulse_ss();
      cyc(5);
      pulse_ss();
      tests++; if (digits !== 16'h0000 || running !== 1'b1) begin fails++; $display("FAIL resume_pre: digits=%h running=%b want 0000 1", digits, running); end
      cyc(1);
      tests++; if (digits !== 16'h0001) begin fails++; $display("FAIL resume_phase: got %h want 0001", digits); end
   endtask

   task automatic test_wrap;
      int early_wrap;
      int bad_bcd;
      early_wrap = 0;
      bad_bcd = 0;
      do_reset();
      pulse_ss();
      for (int i = 0; i < 23996; i++) begin
         cyc(1);
         if (wrap !== 1'b0) early_wrap++;
         if (digits[15:12] > 4'd5 || digits[11:8] > 4'd9 || digits[7:4] > 4'd9 || digits[3:0] > 4'd9) bad_bcd++;
      end
      tests++; if (early_wrap !== 0) begin fails++; $display("FAIL wrap_early: got %0d pulses want 0", early_wrap); end
      tests++; if (bad_bcd !== 0) begin fails++; $display("FAIL wrap_bcd_range: got %0d bad samples want 0", bad_bcd); end
      tests++; if (digits !== 16'h5999) begin fails++; $display("FAIL wrap_5999: got %h want 5999", digits); end
      cyc(3);
      tests++; if (digits !== 16'h5999 || wrap !== 1'b0) begin fails++; $display("FAIL wrap_hold: digits=%h wrap=%b want 5999 0", digits, wrap); end
      cyc(1);
      tests++; if (digits !== 16'h0000 || wrap !== 1'b1) begin fails++; $display("FAIL wrap_roll: digits=%h wrap=%b want 0000 1", digits, wrap); end
      cyc(1);
      tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL wrap_pulse: wrap=%b want 0", wrap); end
   endtask

   task automatic test_lap;
      do_reset();
      pulse_ss();
      cyc(48);
      tests++; if (digits !== 16'h0012) begin fails++; $display("FAIL lap_pre: got %h want 0012", digits); end
      pulse_lap();
`ifdef STOPWATCH_LAP_EN
      tests++; if (lap_active !== 1'b1 || digits !== 16'h0012) begin fails++; $display("FAIL lap_on: lap=%b digits=%h want 1 0012", lap_active, digits); end
      cyc(8);
      tests++; if (digits !== 16'h0012) begin fails++; $display("FAIL lap_frozen: got %h want 0012", digits); end
      pulse_lap();
      tests++; if (lap_active !== 1'b0 || digits !== 16'h0014) begin fails++; $display("FAIL lap_off: lap=%b digits=%h want 0 0014", lap_active, digits); end
      pulse_ss();
      pulse_lap();
      tests++; if (lap_active !== 1'b0) begin fails++; $display("FAIL lap_stopped: lap=%b want 0", lap_active); end
      pulse_ss();
      pulse_lap();
      tests++; if (lap_active !== 1'b1) begin fails++; $display("FAIL lap_on2: lap=%b want 1", lap_active); end
      pulse_ss();
      clear = 1'b1; cyc(1); clear = 1'b0;
      tests++; if (lap_active !== 1'b0 || digits !== 16'h0000) begin fails++; $display("FAIL lap_clear: lap=%b digits=%h want 0 0000", lap_active, digits); end
`else
      tests++; if (lap_active !== 1'b0 || digits !== 16'h0012) begin fails++; $display("FAIL lap_ignored: lap=%b digits=%h want 0 0012", lap_active, digits); end
      cyc(8);
      tests++; if (digits !== 16'h0014) begin fails++; $display("FAIL lap_live: got %h want 0014", digits); end
`endif
   endtask

   initial begin
      test_reset();
      test_start();
      test_ready_gate();
      test_clear();
      test_stop_resume();
      test_wrap();
      test_lap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
